mmu_bus_arbiter: RTL and testbench

MMU_BUS_ARBITER -- requirements
Module: mmu_bus_arbiter

---
 rtl/mmu_bus_arbiter_if.sv | 40 ++++
 rtl/mmu_bus_arbiter.sv | 114 +++++++++++
 tb/tb_mmu_bus_arbiter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmu_bus_arbiter_if.sv
// mmu_bus_arbiter_if: bus operation type and the grouped CPU, DMA and MMU signals of the arbiter.
// The slave modport is the arbiter's view; master is the requester/MMU side.
`ifndef MMU_BUS_ARBITER_IF_SV
`define MMU_BUS_ARBITER_IF_SV
package mmu_bus_pkg;
    typedef enum logic [1:0] {BUS_IDLE, BUS_READ, BUS_WRITE, BUS_FINISHED_OP} bus_op_t;
endpackage

interface mmu_bus_arbiter_if;
    import mmu_bus_pkg::*;
    bus_op_t     cpu_op;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_done;
    bus_op_t     dma_op;
    logic [15:0] dma_addr;
    logic [7:0]  dma_wdata;
    logic [7:0]  dma_rdata;
    logic        dma_done;
    bus_op_t     mem_op;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    bus_op_t     mem_status;
    logic        grant_cpu;
    logic        grant_dma;
    logic        timeout_err;
    modport slave (
        input  cpu_op, cpu_addr, cpu_wdata, dma_op, dma_addr, dma_wdata, mem_rdata, mem_status,
        output cpu_rdata, cpu_done, dma_rdata, dma_done, mem_op, mem_addr, mem_wdata,
               grant_cpu, grant_dma, timeout_err
    );
    modport master (
        output cpu_op, cpu_addr, cpu_wdata, dma_op, dma_addr, dma_wdata, mem_rdata, mem_status,
        input  cpu_rdata, cpu_done, dma_rdata, dma_done, mem_op, mem_addr, mem_wdata,
               grant_cpu, grant_dma, timeout_err
    );
endinterface
`endif

// File: rtl/mmu_bus_arbiter.sv
// mmu_bus_arbiter: shares one MMU bus between CPU and DMA, with a per-transfer completion timeout.
// Define MMU_ARB_ROUND_ROBIN_EN for alternating tie-breaks; otherwise DMA has fixed priority.
`include "mmu_bus_arbiter_if.sv"
module mmu_bus_arbiter
    import mmu_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic clk,
    input logic reset,
    mmu_bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_RELEASE} arb_state_t;

    arb_state_t  r_state;
    bus_op_t     r_mem_op;
    logic [15:0] r_mem_addr;
    logic [7:0]  r_mem_wdata;
    logic [7:0]  r_cpu_rdata;
    logic [7:0]  r_dma_rdata;
    logic        r_cpu_done;
    logic        r_dma_done;
    logic        r_grant_cpu;
    logic        r_grant_dma;
    logic        r_timeout;
    logic [7:0]  r_wait;

    logic w_cpu_req;
    logic w_dma_req;
    logic w_pick_dma;
    logic w_finished;
    logic w_expire;

    assign w_cpu_req  = bus.cpu_op == BUS_READ || bus.cpu_op == BUS_WRITE;
    assign w_dma_req  = bus.dma_op == BUS_READ || bus.dma_op == BUS_WRITE;
    assign w_finished = bus.mem_status == BUS_FINISHED_OP;
    // the wait counter reaches TIMEOUT_CYCLES on the edge that would increment it from TIMEOUT_CYCLES-1
    assign w_expire   = r_wait == 8'(TIMEOUT_CYCLES - 1);

`ifdef MMU_ARB_ROUND_ROBIN_EN
    logic r_last_dma;
    assign w_pick_dma = w_dma_req && (!w_cpu_req || !r_last_dma);
    always_ff @(posedge clk)
        if (reset)
            r_last_dma <= 1'b0;
        else if (r_state == ARB_IDLE && (w_cpu_req || w_dma_req))
            r_last_dma <= w_pick_dma;
`else
    assign w_pick_dma = w_dma_req;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ARB_IDLE;
            r_mem_op    <= BUS_IDLE;
            r_mem_addr  <= 16'h0;
            r_mem_wdata <= 8'h0;
            r_cpu_rdata <= 8'h0;
            r_dma_rdata <= 8'h0;
            r_cpu_done  <= 1'b0;
            r_dma_done  <= 1'b0;
            r_grant_cpu <= 1'b0;
            r_grant_dma <= 1'b0;
            r_timeout   <= 1'b0;
            r_wait      <= 8'h0;
        end else begin
            r_cpu_done <= 1'b0;
            r_dma_done <= 1'b0;
            r_timeout  <= 1'b0;
            case (r_state)
                ARB_IDLE:
                    if (w_cpu_req || w_dma_req) begin
                        r_state     <= ARB_BUSY;
                        r_wait      <= 8'h0;
                        r_grant_dma <= w_pick_dma;
                        r_grant_cpu <= !w_pick_dma;
                        r_mem_op    <= w_pick_dma ? bus.dma_op : bus.cpu_op;
                        r_mem_addr  <= w_pick_dma ? bus.dma_addr : bus.cpu_addr;
                        r_mem_wdata <= w_pick_dma ? bus.dma_wdata : bus.cpu_wdata;
                    end
                ARB_BUSY:
                    if (w_finished || w_expire) begin
                        r_state     <= ARB_RELEASE;
                        r_mem_op    <= BUS_IDLE;
                        r_grant_cpu <= 1'b0;
                        r_grant_dma <= 1'b0;
                        r_cpu_done  <= r_grant_cpu;
                        r_dma_done  <= r_grant_dma;
                        r_timeout   <= !w_finished;
                        r_wait      <= r_wait + 8'd1;
                        if (r_grant_cpu)
                            r_cpu_rdata <= w_finished ? bus.mem_rdata : 8'hFF;
                        if (r_grant_dma)
                            r_dma_rdata <= w_finished ? bus.mem_rdata : 8'hFF;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                default:
                    r_state <= ARB_IDLE;
            endcase
        end
    end

    assign bus.mem_op      = r_mem_op;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_wdata   = r_mem_wdata;
    assign bus.cpu_rdata   = r_cpu_rdata;
    assign bus.dma_rdata   = r_dma_rdata;
    assign bus.cpu_done    = r_cpu_done;
    assign bus.dma_done    = r_dma_done;
    assign bus.grant_cpu   = r_grant_cpu;
    assign bus.grant_dma   = r_grant_dma;
    assign bus.timeout_err = r_timeout;
endmodule

// File: tb/tb_mmu_bus_arbiter.sv
// tb_mmu_bus_arbiter: random CPU/DMA traffic checked every cycle against a transaction-level model,
// plus directed scenarios with hand-computed expectations.
`include "mmu_bus_arbiter_if.sv"
module tb_mmu_bus_arbiter;
    import mmu_bus_pkg::*;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    mmu_bus_arbiter_if bus();
    mmu_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", n, got, exp, $time);
        end
    endtask

    // transaction-level reference: who owns the bus, how long it has waited, one cool-down cycle after each transfer
    int          own = -1;
    int          age = 0;
    bit          cool = 0;
    bit          mdl_ok = 0;
`ifdef MMU_ARB_ROUND_ROBIN_EN
    bit          last_dma = 0;
`endif
    bus_op_t     e_op = BUS_IDLE;
    logic [15:0] e_addr = 16'h0;
    logic [7:0]  e_wd = 8'h0;
    logic [7:0]  e_rd [2] = '{8'h0, 8'h0};
    bit          e_done [2] = '{0, 0};
    bit          e_grant [2] = '{0, 0};
    bit          e_to = 0;

    function automatic bit is_req(bus_op_t op);
        return op == BUS_READ || op == BUS_WRITE;
    endfunction

    always @(posedge clk) begin
        bit want [2];
        bit fin;
        int w;
        e_done = '{0, 0};
        e_to = 0;
        if (reset) begin
            own = -1; age = 0; cool = 0; mdl_ok = 1;
`ifdef MMU_ARB_ROUND_ROBIN_EN
            last_dma = 0;
`endif
            e_op = BUS_IDLE; e_addr = 16'h0; e_wd = 8'h0; e_rd = '{8'h0, 8'h0}; e_grant = '{0, 0};
        end else if (cool) begin
            cool = 0;
        end else if (own < 0) begin
            want[0] = is_req(bus.cpu_op);
            want[1] = is_req(bus.dma_op);
            if (want[0] || want[1]) begin
`ifdef MMU_ARB_ROUND_ROBIN_EN
                w = (want[0] && want[1]) ? (last_dma ? 0 : 1) : (want[1] ? 1 : 0);
                last_dma = w == 1;
`else
                w = want[1] ? 1 : 0;
`endif
                own = w; age = 0; e_grant[w] = 1;
                e_op   = w == 1 ? bus.dma_op : bus.cpu_op;
                e_addr = w == 1 ? bus.dma_addr : bus.cpu_addr;
                e_wd   = w == 1 ? bus.dma_wdata : bus.cpu_wdata;
            end
        end else begin
            fin = bus.mem_status == BUS_FINISHED_OP;
            age++;
            if (fin || age == TO) begin
                e_rd[own] = fin ? bus.mem_rdata : 8'hFF;
                e_done[own] = 1; e_to = !fin;
                e_op = BUS_IDLE; e_grant = '{0, 0}; own = -1; cool = 1;
            end
        end
    end

    always @(negedge clk) if (mdl_ok) begin
        chk("mem_op", 32'(bus.mem_op), 32'(e_op));
        chk("grant_cpu", 32'(bus.grant_cpu), 32'(e_grant[0]));
        chk("grant_dma", 32'(bus.grant_dma), 32'(e_grant[1]));
        chk("cpu_done", 32'(bus.cpu_done), 32'(e_done[0]));
        chk("dma_done", 32'(bus.dma_done), 32'(e_done[1]));
        chk("timeout_err", 32'(bus.timeout_err), 32'(e_to));
        chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(e_rd[0]));
        chk("dma_rdata", 32'(bus.dma_rdata), 32'(e_rd[1]));
        if (e_op != BUS_IDLE) begin
            chk("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
            chk("mem_wdata", 32'(bus.mem_wdata), 32'(e_wd));
        end
    end

    // stimulus: MMU responder with fixed or random latency, optional random requesters and resets
    int       fix_lat = 0;
    logic [7:0] fix_rd = 8'h0;
    bit       rnd = 0;
    bit       m_act = 0;
    int       m_k = 0;
    int       m_lat = 0;
    bit       pend_c = 0;
    bit       pend_d = 0;

    task automatic step();
        @(negedge clk);
        if (bus.mem_op != BUS_IDLE) begin
            if (!m_act) begin
                m_act = 1; m_k = 0;
                m_lat = fix_lat >= 0 ? fix_lat : int'($urandom_range(0, 5));
            end
            bus.mem_status = m_k == m_lat ? BUS_FINISHED_OP : BUS_IDLE;
            m_k++;
        end else begin
            m_act = 0;
            bus.mem_status = BUS_IDLE;
        end
        bus.mem_rdata = rnd ? 8'($urandom) : fix_rd;
        if (rnd) begin
            reset = $urandom_range(0, 299) == 0;
            if (bus.cpu_done) begin
                bus.cpu_op = BUS_IDLE; pend_c = 0;
            end else if (!pend_c && $urandom_range(0, 3) == 0) begin
                bus.cpu_op = $urandom_range(0, 1) ? BUS_WRITE : BUS_READ;
                bus.cpu_addr = 16'($urandom); bus.cpu_wdata = 8'($urandom); pend_c = 1;
            end else if (pend_c && bus.grant_cpu && $urandom_range(0, 15) == 0) begin
                bus.cpu_op = BUS_IDLE; pend_c = 0;
            end
            if (bus.dma_done) begin
                bus.dma_op = BUS_IDLE; pend_d = 0;
            end else if (!pend_d && $urandom_range(0, 3) == 0) begin
                bus.dma_op = $urandom_range(0, 1) ? BUS_WRITE : BUS_READ;
                bus.dma_addr = 16'($urandom); bus.dma_wdata = 8'($urandom); pend_d = 1;
            end else if (pend_d && bus.grant_dma && $urandom_range(0, 15) == 0) begin
                bus.dma_op = BUS_IDLE; pend_d = 0;
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.cpu_done) bus.cpu_op = BUS_IDLE;
            if (bus.dma_done) bus.dma_op = BUS_IDLE;
        end
    endtask

    initial begin
        int win [$];
        int exp_w [3];
        bit prev;
        int dc;
        int n;
        bus.cpu_op = BUS_IDLE; bus.cpu_addr = 16'h0; bus.cpu_wdata = 8'h0;
        bus.dma_op = BUS_IDLE; bus.dma_addr = 16'h0; bus.dma_wdata = 8'h0;
        bus.mem_status = BUS_IDLE; bus.mem_rdata = 8'h0;
        repeat (2) step();
        chk("rst_mem_op", 32'(bus.mem_op), 32'(BUS_IDLE));
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
        chk("rst_grants", 32'({bus.grant_cpu, bus.grant_dma}), 32'h0);
        chk("rst_rdata", 32'({bus.cpu_rdata, bus.dma_rdata}), 32'h0);
        reset = 1'b0;

        fix_lat = 2; fix_rd = 8'h5A;
        bus.cpu_op = BUS_READ; bus.cpu_addr = 16'hC000;
        step();
        chk("r032_addr", 32'(bus.mem_addr), 32'hC000);
        chk("r032_op", 32'(bus.mem_op), 32'(BUS_READ));
        chk("r032_grant", 32'(bus.grant_cpu), 32'h1);
        dc = 0; n = 0;
        for (int i = 2; i <= 6; i++) begin
            step();
            if (bus.cpu_done) begin dc++; n = i; bus.cpu_op = BUS_IDLE; end
            chk("r032_dma_done", 32'(bus.dma_done), 32'h0);
        end
        chk("r032_done_cnt", 32'(dc), 32'd1);
        chk("r032_done_cyc", 32'(n), 32'd4);
        chk("r032_rdata", 32'(bus.cpu_rdata), 32'h5A);

        fix_lat = 1; fix_rd = 8'h77;
        bus.dma_op = BUS_WRITE; bus.dma_addr = 16'hFE10; bus.dma_wdata = 8'h3C;
        step();
        chk("r033_op", 32'(bus.mem_op), 32'(BUS_WRITE));
        chk("r033_wdata", 32'(bus.mem_wdata), 32'h3C);
        chk("r033_addr", 32'(bus.mem_addr), 32'hFE10);
        chk("r033_grant", 32'({bus.grant_cpu, bus.grant_dma}), 32'h1);
        step();
        chk("r033_grant_hold", 32'(bus.grant_dma), 32'h1);
        chk("r033_early_done", 32'(bus.dma_done), 32'h0);
        step();
        chk("r033_done", 32'(bus.dma_done), 32'h1);
        chk("r033_wr_rdata", 32'(bus.dma_rdata), 32'h77);
        chk("r033_cpu_rdata_kept", 32'(bus.cpu_rdata), 32'h5A);
        bus.dma_op = BUS_IDLE; bus.cpu_op = BUS_READ; bus.cpu_addr = 16'h1234;
        step();
        chk("r033_release_nogrant", 32'({bus.grant_cpu, bus.grant_dma}), 32'h0);
        chk("r033_done_once", 32'(bus.dma_done), 32'h0);
        step();
        chk("r033_next_grant", 32'(bus.grant_cpu), 32'h1);
        chk("r033_next_addr", 32'(bus.mem_addr), 32'h1234);
        drain();

        reset = 1'b1;
        step();
        reset = 1'b0;
        fix_lat = 0;
`ifdef MMU_ARB_ROUND_ROBIN_EN
        exp_w = '{1, 0, 1};
`else
        exp_w = '{1, 1, 1};
`endif
        bus.cpu_op = BUS_READ; bus.cpu_addr = 16'h1111;
        bus.dma_op = BUS_READ; bus.dma_addr = 16'h2222;
        prev = 0;
        for (int i = 0; i < 30 && win.size() < 3; i++) begin
            step();
            if ((bus.grant_cpu || bus.grant_dma) && !prev) win.push_back(bus.grant_dma ? 1 : 0);
            prev = bus.grant_cpu || bus.grant_dma;
        end
        chk("r034_grants", 32'(win.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            chk("r034_order", i < win.size() ? 32'(win[i]) : 32'd9, 32'(exp_w[i]));
        bus.cpu_op = BUS_IDLE; bus.dma_op = BUS_IDLE;
        drain();

        fix_lat = 100;
        bus.cpu_op = BUS_READ; bus.cpu_addr = 16'h4000;
        step();
        chk("r035_grant", 32'(bus.grant_cpu), 32'h1);
        for (int i = 2; i <= 4; i++) begin
            step();
            chk("r035_early_to", 32'({bus.timeout_err, bus.cpu_done}), 32'h0);
        end
        step();
        chk("r035_to", 32'(bus.timeout_err), 32'h1);
        chk("r035_done", 32'(bus.cpu_done), 32'h1);
        chk("r035_rdata", 32'(bus.cpu_rdata), 32'hFF);
        chk("r035_mem_op", 32'(bus.mem_op), 32'(BUS_IDLE));
        bus.cpu_op = BUS_IDLE;
        step();
        chk("r035_to_pulse", 32'({bus.timeout_err, bus.cpu_done}), 32'h0);
        chk("r035_mem_op_after", 32'(bus.mem_op), 32'(BUS_IDLE));
        drain();

        bus.dma_op = BUS_READ; bus.dma_addr = 16'h8000;
        step();
        chk("r036_grant", 32'(bus.grant_dma), 32'h1);
        step();
        reset = 1'b1;
        step();
        chk("r036_mem_op", 32'(bus.mem_op), 32'(BUS_IDLE));
        chk("r036_grants", 32'({bus.grant_cpu, bus.grant_dma}), 32'h0);
        chk("r036_done", 32'(bus.dma_done), 32'h0);
        reset = 1'b0; bus.dma_op = BUS_IDLE;
        step();
        chk("r036_no_done", 32'({bus.dma_done, bus.timeout_err}), 32'h0);

        fix_lat = -1; rnd = 1;
        repeat (4000) step();
        rnd = 0; reset = 1'b0;
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
